matrix_scan_arbiter: RTL and testbench

Shares the single-port data memory between the CPU load/store path and the LED-matrix refresh scanner. Internally generates game-board scan addresses 0x0100..0x01FF and fetches each word. Hands each word to the matrix driver over a valid/ready handshake. Pulses frame_done at each wrap. Sits between the CPU memory stage, the data RAM and the matrix driver.

---
 rtl/matrix_scan_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_matrix_scan_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_scan_arbiter.sv
// matrix_scan_arbiter
// Shares the single-port data RAM between the CPU load/store path and the
// LED-matrix refresh scanner. The scanner walks BASE_ADDR..END_ADDR, fetches
// each word and offers it to the matrix driver over a valid/ready handshake.
// A starvation counter lets a waiting scan read through after STARVE_LIMIT
// consecutive CPU grants.
// Optional feature macro: MATRIX_SCAN_STATS_EN adds the frame_cnt and
// starve_hit outputs.
module matrix_scan_arbiter #(
    parameter logic [15:0] BASE_ADDR    = 16'h0100,
    parameter logic [15:0] END_ADDR     = 16'h01FF,
    parameter int          MEM_LAT      = 1,
    parameter int          STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic [15:0] cpu_rdata,
    output logic        cpu_rvalid,
    input  logic        scan_en,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic [15:0] pix_data,
    output logic [7:0]  pix_offset,
    output logic        pix_valid,
    input  logic        pix_ready,
`ifdef MATRIX_SCAN_STATS_EN
    output logic [15:0] frame_cnt,
    output logic        starve_hit,
`endif
    output logic        frame_done
);

    localparam int              SW    = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]   LIMIT = SW'(STARVE_LIMIT);
    localparam logic [1:0]      LAT   = 2'(MEM_LAT);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CPU_WAIT  = 2'd1,
        SCAN_WAIT = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [1:0]      lat_cnt;
    logic            acc_we;
    logic [15:0]     scan_ptr;
    logic [SW-1:0]   starve_cnt;

    logic            scan_want;
    logic            cpu_win;
    logic            scan_win;
    logic            lat_done;
    logic            accept;
    logic            at_end;

    logic            mem_en_d;
    logic            mem_we_d;
    logic [15:0]     mem_addr_d;
    logic [15:0]     mem_wdata_d;
    logic            cpu_gnt_d;
    logic            cpu_rvalid_d;
    logic [15:0]     cpu_rdata_d;
    logic            pix_valid_d;
    logic [15:0]     pix_data_d;
    logic [7:0]      pix_offset_d;
    logic            frame_done_d;
    logic [15:0]     scan_ptr_d;
    logic [SW-1:0]   starve_d;
    logic [1:0]      lat_cnt_d;
    logic            acc_we_d;

    // A scan read is only wanted when the previous pixel has been handed off.
    // The CPU wins unless the scanner has already been passed over STARVE_LIMIT times.
    assign scan_want = scan_en && !pix_valid && (state == IDLE);
    assign cpu_win   = (state == IDLE) && cpu_req && !(scan_want && (starve_cnt == LIMIT));
    assign scan_win  = scan_want && !cpu_win;
    assign lat_done  = (lat_cnt == LAT);
    assign accept    = pix_valid && pix_ready;
    assign at_end    = (scan_ptr == END_ADDR);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: writes finish after their issue cycle, reads wait out MEM_LAT
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cpu_win) begin
                    state_next = CPU_WAIT;
                end else if (scan_win) begin
                    state_next = SCAN_WAIT;
                end
            end
            CPU_WAIT: begin
                if (acc_we || lat_done) begin
                    state_next = IDLE;
                end
            end
            SCAN_WAIT: begin
                if (lat_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic: next values of every registered output and datapath register
    always_comb begin
        mem_en_d    = cpu_win || scan_win;
        mem_we_d    = cpu_win && cpu_we;
        mem_addr_d  = 16'h0000;
        if (cpu_win) begin
            mem_addr_d = cpu_addr;
        end else if (scan_win) begin
            mem_addr_d = scan_ptr;
        end
        mem_wdata_d = (cpu_win && cpu_we) ? cpu_wdata : 16'h0000;
        cpu_gnt_d   = cpu_win;

        cpu_rvalid_d = (state == CPU_WAIT) && !acc_we && lat_done;
        cpu_rdata_d  = cpu_rvalid_d ? mem_rdata : cpu_rdata;

        pix_valid_d  = pix_valid;
        pix_data_d   = pix_data;
        pix_offset_d = pix_offset;
        if ((state == SCAN_WAIT) && lat_done) begin
            pix_valid_d  = 1'b1;
            pix_data_d   = mem_rdata;
            pix_offset_d = 8'(scan_ptr - BASE_ADDR);
        end else if (accept) begin
            pix_valid_d = 1'b0;
        end

        frame_done_d = accept && at_end;
        scan_ptr_d   = scan_ptr;
        if (accept) begin
            scan_ptr_d = at_end ? BASE_ADDR : scan_ptr + 16'd1;
        end

        starve_d = starve_cnt;
        if (cpu_win && scan_want) begin
            starve_d = starve_cnt + SW'(1);
        end else if (scan_win) begin
            starve_d = '0;
        end

        lat_cnt_d = (state == IDLE) ? 2'd0 : lat_cnt + 2'd1;
        acc_we_d  = cpu_win ? cpu_we : acc_we;
    end

    // Output and datapath registers; reset abandons any in-flight access
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 16'h0000;
            mem_wdata  <= 16'h0000;
            cpu_gnt    <= 1'b0;
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= 16'h0000;
            pix_valid  <= 1'b0;
            pix_data   <= 16'h0000;
            pix_offset <= 8'h00;
            frame_done <= 1'b0;
            scan_ptr   <= BASE_ADDR;
            starve_cnt <= '0;
            lat_cnt    <= 2'd0;
            acc_we     <= 1'b0;
        end else begin
            mem_en     <= mem_en_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            cpu_gnt    <= cpu_gnt_d;
            cpu_rvalid <= cpu_rvalid_d;
            cpu_rdata  <= cpu_rdata_d;
            pix_valid  <= pix_valid_d;
            pix_data   <= pix_data_d;
            pix_offset <= pix_offset_d;
            frame_done <= frame_done_d;
            scan_ptr   <= scan_ptr_d;
            starve_cnt <= starve_d;
            lat_cnt    <= lat_cnt_d;
            acc_we     <= acc_we_d;
        end
    end

`ifdef MATRIX_SCAN_STATS_EN
    // Frame counter and a pulse whenever the starvation limit forces a scan grant
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt  <= 16'h0000;
            starve_hit <= 1'b0;
        end else begin
            if (frame_done_d) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            starve_hit <= scan_win && cpu_req;
        end
    end
`endif

endmodule

// File: tb/tb_matrix_scan_arbiter.sv
// tb_matrix_scan_arbiter
// Randomized bench for matrix_scan_arbiter. A timestamp-based reference model
// (per-cycle busy window, due cycles for read data and pixels, a scan pointer
// and a starvation count) predicts every strobe, rvalid, pixel and frame pulse.
module tb_matrix_scan_arbiter;

    localparam logic [15:0] BASE  = 16'h0100;
    localparam logic [15:0] LAST  = 16'h01FF;
    localparam int          LAT   = 1;
    localparam int          LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [15:0] cpu_wdata = 16'h0000;
    logic        cpu_gnt;
    logic [15:0] cpu_rdata;
    logic        cpu_rvalid;
    logic        scan_en = 1'b0;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = 16'h0000;
    logic [15:0] pix_data;
    logic [7:0]  pix_offset;
    logic        pix_valid;
    logic        pix_ready = 1'b0;
    logic        frame_done;
`ifdef MATRIX_SCAN_STATS_EN
    logic [15:0] frame_cnt;
    logic        starve_hit;
`endif

    always #5 clk = ~clk;

    matrix_scan_arbiter #(
        .BASE_ADDR(BASE), .END_ADDR(LAST), .MEM_LAT(LAT), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .scan_en(scan_en),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .pix_data(pix_data), .pix_offset(pix_offset), .pix_valid(pix_valid),
        .pix_ready(pix_ready),
`ifdef MATRIX_SCAN_STATS_EN
        .frame_cnt(frame_cnt), .starve_hit(starve_hit),
`endif
        .frame_done(frame_done)
    );

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
    } req_t;

    logic [15:0] ram [0:65535];
    req_t        dq[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int          busy_until, rv_due, pix_due, rd_due, starve;
    logic [15:0] m_ptr, rv_addr, pix_addr, rd_addr, m_pix_data, m_fcnt;
    logic [7:0]  m_pix_off;
    logic        m_pv, pv_accept, fd_exp;
    logic        p_idle, p_req, p_we, p_want;
    logic [15:0] p_addr, p_wdata;

    int cpu_pct, we_pct, scan_pct, ready_pct, drop_pct;
    int frames_seen, gnts_seen, forced_seen;
    logic        scan_seen;
    logic [15:0] first_scan, last_rdata;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h exp=%h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic setKnobs(input int c, input int w, input int s, input int r, input int d);
        cpu_pct = c; we_pct = w; scan_pct = s; ready_pct = r; drop_pct = d;
    endtask

    task automatic resetModel();
        busy_until = -1; rv_due = -1; pix_due = -1; rd_due = -1; starve = 0;
        m_ptr = BASE; m_pv = 1'b0; pv_accept = 1'b0; fd_exp = 1'b0; m_fcnt = 16'h0000;
        frames_seen = 0; scan_seen = 1'b0; first_scan = 16'h0000;
    endtask

    // CPU agent plus scan_en / pix_ready for the cycle that just started
    task automatic driveInputs();
        logic withdrawn;
        withdrawn = 1'b0;
        if (cpu_gnt) begin
            cpu_req = 1'b0;
            gnts_seen++;
        end else if (cpu_req && ($urandom_range(99) < drop_pct)) begin
            cpu_req = 1'b0;
            withdrawn = 1'b1;
        end
        if (!cpu_req && !withdrawn) begin
            if (dq.size() > 0) begin
                req_t r;
                r = dq.pop_front();
                cpu_req = 1'b1; cpu_we = r.we; cpu_addr = r.addr; cpu_wdata = r.data;
            end else if ($urandom_range(99) < cpu_pct) begin
                cpu_req   = 1'b1;
                cpu_we    = ($urandom_range(99) < we_pct);
                cpu_addr  = ($urandom_range(1) == 1) ? BASE + 16'($urandom_range(255))
                                                     : 16'h0200 + 16'($urandom_range(15));
                cpu_wdata = 16'($urandom);
            end
        end
        scan_en   = ($urandom_range(99) < scan_pct);
        pix_ready = ($urandom_range(99) < ready_pct);
    endtask

    // Capture what the arbiter will see at the coming clock edge
    task automatic latchPrev();
        p_idle    = (cyc > busy_until);
        p_req     = cpu_req;
        p_we      = cpu_we;
        p_addr    = cpu_addr;
        p_wdata   = cpu_wdata;
        p_want    = scan_en && !m_pv && p_idle;
        pv_accept = m_pv && pix_ready;
    endtask

    task automatic stepCycle();
        logic        cw, e_en, e_gnt, e_we, e_hit;
        logic [15:0] e_addr;
        @(negedge clk);
        cyc++;
        fd_exp = 1'b0;
        if (pv_accept) begin
            m_pv = 1'b0;
            pv_accept = 1'b0;
            if (m_ptr == LAST) begin
                m_ptr = BASE; fd_exp = 1'b1; m_fcnt = m_fcnt + 16'd1;
            end else begin
                m_ptr = m_ptr + 16'd1;
            end
        end
        e_en = 1'b0; e_gnt = 1'b0; e_we = 1'b0; e_hit = 1'b0; e_addr = 16'h0000;
        if (p_idle && (p_req || p_want)) begin
            cw = p_req && !(p_want && starve == LIMIT);
            e_en = 1'b1;
            if (cw) begin
                e_gnt = 1'b1; e_we = p_we; e_addr = p_addr;
                if (p_want) starve++;
                if (p_we) begin
                    busy_until = cyc;
                end else begin
                    busy_until = cyc + LAT; rv_due = cyc + LAT + 1; rv_addr = p_addr;
                end
            end else begin
                e_hit = p_req; e_addr = m_ptr; starve = 0;
                if (p_req) forced_seen++;
                busy_until = cyc + LAT; pix_due = cyc + LAT + 1; pix_addr = m_ptr;
            end
        end
        checkOutput("strobe", 32'({mem_en, cpu_gnt, mem_we, (mem_en ? mem_addr : 16'h0000)}),
                    32'({e_en, e_gnt, e_we, e_addr}));
        if (e_en && e_we) checkOutput("wdata", 32'(mem_wdata), 32'(p_wdata));

        if (mem_en && mem_we) ram[mem_addr] = mem_wdata;
        if (mem_en && !mem_we) begin
            rd_due = cyc + LAT; rd_addr = mem_addr;
        end
        if (cyc == rd_due) mem_rdata = ram[rd_addr];
        else mem_rdata = 16'($urandom);
        if (mem_en && !cpu_gnt && !scan_seen) begin
            scan_seen = 1'b1; first_scan = mem_addr;
        end
        if (frame_done) frames_seen++;

        checkOutput("rvalid", 32'(cpu_rvalid), 32'(cyc == rv_due));
        if (cyc == rv_due) begin
            checkOutput("rdata", 32'(cpu_rdata), 32'(ram[rv_addr]));
            last_rdata = cpu_rdata;
        end
        if (cyc == pix_due) begin
            m_pv = 1'b1; m_pix_data = ram[pix_addr]; m_pix_off = 8'(pix_addr - BASE);
        end
        checkOutput("pix_valid", 32'(pix_valid), 32'(m_pv));
        if (m_pv) checkOutput("pix_word", 32'({pix_offset, pix_data}), 32'({m_pix_off, m_pix_data}));
        checkOutput("frame_done", 32'(frame_done), 32'(fd_exp));
`ifdef MATRIX_SCAN_STATS_EN
        checkOutput("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
        checkOutput("starve_hit", 32'(starve_hit), 32'(e_hit));
`endif
        driveInputs();
        latchPrev();
    endtask

    task automatic applyStimulus(input int n);
        repeat (n) stepCycle();
    endtask

    task automatic doReset();
        #2;
        reset = 1'b1;
        #1;
        checkOutput("reset_ctl", 32'({mem_en, mem_we, cpu_gnt, cpu_rvalid, pix_valid, frame_done}), 32'd0);
        checkOutput("reset_data", 32'(|{mem_addr, mem_wdata, cpu_rdata, pix_data, pix_offset}), 32'd0);
`ifdef MATRIX_SCAN_STATS_EN
        checkOutput("reset_stats", 32'({frame_cnt, starve_hit}), 32'd0);
`endif
        repeat (3) begin
            @(negedge clk);
            cyc++;
        end
        resetModel();
        dq.delete();
        cpu_req = 1'b0;
        reset = 1'b0;
        mem_rdata = 16'($urandom);
        driveInputs();
        latchPrev();
    endtask

    initial begin
        logic found;
        for (int i = 0; i < 65536; i++) ram[i] = 16'($urandom);
        gnts_seen = 0; forced_seen = 0; last_rdata = 16'h0000;
        resetModel();

        $display("[TB] scan-only refresh, one frame");
        setKnobs(0, 0, 100, 100, 0);
        repeat (2) @(negedge clk);
        doReset();
        applyStimulus(1100);
        checkOutput("frames_1", 32'(frames_seen), 32'd1);

        $display("[TB] CPU write then read with scan disabled");
        setKnobs(0, 0, 0, 100, 0);
        applyStimulus(10);
        gnts_seen = 0;
        dq.push_back(req_t'{1'b1, 16'h0150, 16'hBEEF});
        dq.push_back(req_t'{1'b0, 16'h0150, 16'h0000});
        applyStimulus(12);
        checkOutput("gnt_count", 32'(gnts_seen), 32'd2);
        checkOutput("beef", 32'(last_rdata), 32'h0000BEEF);

        $display("[TB] continuous CPU reads against scan");
        setKnobs(100, 0, 100, 100, 0);
        forced_seen = 0;
        applyStimulus(300);
        checkOutput("forced_seen", 32'(forced_seen > 0), 32'd1);

        $display("[TB] driver stalls pixel");
        setKnobs(50, 30, 100, 0, 0);
        applyStimulus(25);
        setKnobs(50, 30, 100, 100, 0);
        applyStimulus(10);

        $display("[TB] random traffic");
        for (int b = 0; b < 20; b++) begin
            setKnobs($urandom_range(100), $urandom_range(100), $urandom_range(100),
                     $urandom_range(100), 10);
            applyStimulus(100);
        end

        $display("[TB] reset during scan read of 0x01A0");
        setKnobs(0, 0, 100, 100, 0);
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            stepCycle();
            if (mem_en && !cpu_gnt && mem_addr == 16'h01A0) found = 1'b1;
        end
        checkOutput("reach_1a0", 32'(found), 32'd1);
        doReset();

        $display("[TB] three frames after reset");
        applyStimulus(3100);
        checkOutput("restart_addr", 32'(first_scan), 32'(BASE));
        checkOutput("frames_3", 32'(frames_seen), 32'd3);
`ifdef MATRIX_SCAN_STATS_EN
        checkOutput("frame_cnt_3", 32'(frame_cnt), 32'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
